// File: rtl/tcp_arb_pkg.sv
// Shared definitions for the TCP transmit arbiter: FSM states, the status
// word field offsets and the completion error codes.
package tcp_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_META     = 3'd1,
        ST_WAIT_STS = 3'd2,
        ST_DATA     = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_RESP     = 3'd5
    } arb_state_e;

    // Status word layout: [15:0] session, [31:16] length, [61:32] space, [63:62] error
    localparam int STS_SESS_LSB = 0;
    localparam int STS_ERR_LSB  = 62;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    function automatic logic [1:0] sts_error(input logic [63:0] word);
        return word[STS_ERR_LSB +: 2];
    endfunction

    function automatic logic [15:0] sts_session(input logic [63:0] word);
        return word[STS_SESS_LSB +: 16];
    endfunction

    // Completion word reported when the stack never answered: {11, 0, length, session}
    function automatic logic [63:0] timeout_word(input logic [31:0] meta);
        return {ERR_TIMEOUT, 30'd0, meta};
    endfunction

endpackage

// File: rtl/tcp_tx_arbiter_rr.sv
// Round-robin grant selection. The search starts one past the last granted
// requester; the pointer only moves when the caller commits a grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       en_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       gnt_valid_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Find the first active requester after last_q, wrapping NUM_REQ-1 -> 0
    always_comb begin
        gnt_idx_o   = last_q;
        gnt_valid_o = 1'b0;
        cand_s      = last_q;
        hit_s       = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s      = IDX_W'((int'(last_q) + i) % NUM_REQ);
            hit_s       = req_i[cand_s] & ~gnt_valid_o;
            gnt_idx_o   = hit_s ? cand_s : gnt_idx_o;
            gnt_valid_o = gnt_valid_o | hit_s;
        end
        gnt_o = gnt_valid_o ? (ONE_HOT0 << gnt_idx_o) : {NUM_REQ{1'b0}};
    end

    // Remember the committed grant so the next search starts after it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (en_i && gnt_valid_o) begin
            last_q <= gnt_idx_o;
        end else begin
            last_q <= last_q;
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Arbitrates NUM_REQ application requesters onto one TCP transmit channel:
// metadata out, wait for the stack status, forward or drain payload, then
// return a completion word to the granted requester.
// Optional build macro TCP_TX_ARB_STATS_EN adds grant/error/timeout counters
// on stat_reg; without it stat_reg is constant zero.
module tcp_tx_arbiter
    import tcp_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250000000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       s_req_meta_valid,
    output logic [NUM_REQ-1:0]       s_req_meta_ready,
    input  logic [NUM_REQ*32-1:0]    s_req_meta_data,
    input  logic [NUM_REQ-1:0]       s_req_data_valid,
    output logic [NUM_REQ-1:0]       s_req_data_ready,
    input  logic [NUM_REQ*512-1:0]   s_req_data_data,
    input  logic [NUM_REQ*64-1:0]    s_req_data_keep,
    input  logic [NUM_REQ-1:0]       s_req_data_last,
    output logic [NUM_REQ-1:0]       m_rsp_valid,
    input  logic [NUM_REQ-1:0]       m_rsp_ready,
    output logic [63:0]              m_rsp_data,
    output logic                     m_axis_tx_metadata_valid,
    input  logic                     m_axis_tx_metadata_ready,
    output logic [31:0]              m_axis_tx_metadata_data,
    output logic                     m_axis_tx_data_valid,
    input  logic                     m_axis_tx_data_ready,
    output logic [511:0]             m_axis_tx_data_data,
    output logic [63:0]              m_axis_tx_data_keep,
    output logic                     m_axis_tx_data_last,
    input  logic                     s_axis_tx_status_valid,
    output logic                     s_axis_tx_status_ready,
    input  logic [63:0]              s_axis_tx_status_data,
    output logic [95:0]              stat_reg
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e       state_q;
    logic [IDX_W-1:0] grant_q;
    logic [31:0]      meta_q;
    logic [63:0]      rsp_q;
    logic [31:0]      tmo_q;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_valid_s;
    logic               arb_en_s;
    logic [31:0]        meta_sel_s;
    logic               sel_dv_s;
    logic               sel_last_s;
    logic [511:0]       sel_data_s;
    logic [63:0]        sel_keep_s;
    logic               sts_bad_s;
    logic               tmo_hit_s;

    assign arb_en_s = (state_q == ST_IDLE);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (s_req_meta_valid),
        .en_i        (arb_en_s),
        .gnt_o       (arb_gnt_s),
        .gnt_idx_o   (arb_idx_s),
        .gnt_valid_o (arb_valid_s)
    );

    // One-hot mux of the metadata belonging to the requester about to be granted
    always_comb begin
        meta_sel_s = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            meta_sel_s = meta_sel_s | (s_req_meta_data[i*32 +: 32] & {32{arb_gnt_s[i]}});
        end
    end

    // Payload of the granted requester and status/timeout decisions
    always_comb begin
        sel_dv_s   = s_req_data_valid[grant_q];
        sel_last_s = s_req_data_last[grant_q];
        sel_data_s = s_req_data_data[int'(grant_q)*512 +: 512];
        sel_keep_s = s_req_data_keep[int'(grant_q)*64 +: 64];
        sts_bad_s  = (sts_error(s_axis_tx_status_data) != ERR_NONE) ||
                     (sts_session(s_axis_tx_status_data) != meta_q[15:0]);
        tmo_hit_s  = (tmo_q == (TIMEOUT_CYCLES - 32'd1));
    end

    // Transaction FSM: grant, metadata, status wait, payload, completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            meta_q  <= 32'd0;
            rsp_q   <= 64'd0;
            tmo_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        grant_q <= arb_idx_s;
                        meta_q  <= meta_sel_s;
                        state_q <= ST_META;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_META: begin
                    if (m_axis_tx_metadata_ready) begin
                        tmo_q   <= 32'd0;
                        state_q <= ST_WAIT_STS;
                    end else begin
                        state_q <= ST_META;
                    end
                end
                ST_WAIT_STS: begin
                    if (s_axis_tx_status_valid) begin
                        rsp_q   <= s_axis_tx_status_data;
                        state_q <= sts_bad_s ? ST_DRAIN : ST_DATA;
                    end else if (tmo_hit_s) begin
                        rsp_q   <= timeout_word(meta_q);
                        state_q <= ST_DRAIN;
                    end else begin
                        tmo_q   <= tmo_q + 32'd1;
                        state_q <= ST_WAIT_STS;
                    end
                end
                ST_DATA: begin
                    if (sel_dv_s && m_axis_tx_data_ready && sel_last_s) begin
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DRAIN: begin
                    if (sel_dv_s && sel_last_s) begin
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_RESP: begin
                    if (m_rsp_ready[grant_q]) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Interface drive decoded from state; only the granted requester sees ready/valid
    always_comb begin
        s_req_meta_ready         = '0;
        s_req_data_ready         = '0;
        m_rsp_valid              = '0;
        m_rsp_data               = 64'd0;
        m_axis_tx_metadata_valid = 1'b0;
        m_axis_tx_metadata_data  = 32'd0;
        m_axis_tx_data_valid     = 1'b0;
        m_axis_tx_data_data      = 512'd0;
        m_axis_tx_data_keep      = 64'd0;
        m_axis_tx_data_last      = 1'b0;
        s_axis_tx_status_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                m_rsp_data = 64'd0;
            end
            ST_META: begin
                m_axis_tx_metadata_valid  = 1'b1;
                m_axis_tx_metadata_data   = meta_q;
                s_req_meta_ready[grant_q] = m_axis_tx_metadata_ready;
            end
            ST_WAIT_STS: begin
                s_axis_tx_status_ready = 1'b1;
            end
            ST_DATA: begin
                m_axis_tx_data_valid      = sel_dv_s;
                m_axis_tx_data_data       = sel_data_s;
                m_axis_tx_data_keep       = sel_keep_s;
                m_axis_tx_data_last       = sel_last_s;
                s_req_data_ready[grant_q] = m_axis_tx_data_ready;
            end
            ST_DRAIN: begin
                s_req_data_ready[grant_q] = 1'b1;
            end
            ST_RESP: begin
                m_rsp_valid[grant_q] = 1'b1;
                m_rsp_data           = rsp_q;
            end
            default: begin
                m_rsp_data = 64'd0;
            end
        endcase
    end

`ifdef TCP_TX_ARB_STATS_EN
    logic [31:0] grant_cnt_q;
    logic [31:0] error_cnt_q;
    logic [31:0] timeout_cnt_q;

    // Wrapping event counters: grants, bad status (error or wrong session), timeouts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_cnt_q   <= 32'd0;
            error_cnt_q   <= 32'd0;
            timeout_cnt_q <= 32'd0;
        end else begin
            if (arb_en_s && arb_valid_s) begin
                grant_cnt_q <= grant_cnt_q + 32'd1;
            end else begin
                grant_cnt_q <= grant_cnt_q;
            end
            if ((state_q == ST_WAIT_STS) && s_axis_tx_status_valid && sts_bad_s) begin
                error_cnt_q <= error_cnt_q + 32'd1;
            end else begin
                error_cnt_q <= error_cnt_q;
            end
            if ((state_q == ST_WAIT_STS) && !s_axis_tx_status_valid && tmo_hit_s) begin
                timeout_cnt_q <= timeout_cnt_q + 32'd1;
            end else begin
                timeout_cnt_q <= timeout_cnt_q;
            end
        end
    end

    assign stat_reg = {timeout_cnt_q, error_cnt_q, grant_cnt_q};
`else
    assign stat_reg = 96'd0;
`endif

endmodule
